wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 115 +++++++++++
 tb/tb_wb_arbiter2.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone arbiter with bus lock and ack watchdog
module wb_arbiter2 #(
    parameter int round_robin = 1,
    parameter int timeout     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_cyc_i,
    input  logic [1:0]  m_stb_i,
    input  logic [1:0]  m_we_i,
    input  logic [63:0] m_adr_i,
    input  logic [7:0]  m_sel_i,
    input  logic [63:0] m_dat_i,
    output logic [31:0] m_dat_o,
    output logic [1:0]  m_ack_o,
    output logic [1:0]  m_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(timeout);

    state_t     state;
    logic       last_gnt;
    logic [7:0] wd;

    logic       own;
    logic       owner;
    logic       owner_stb;
    logic       timeout_hit;
    logic [1:0] req;

    always_comb begin
        own         = (state != IDLE);
        owner       = (state == OWN1);
        owner_stb   = m_stb_i[owner];
        req         = m_cyc_i & m_stb_i;
        // An ack landing in the watchdog cycle completes the access instead of erroring it.
        timeout_hit = (TIMEOUT_W != 8'd0) && own && owner_stb && !s_ack_i && (wd == TIMEOUT_W);
    end

    always_comb begin
        s_cyc_o = own & m_cyc_i[owner] & ~timeout_hit;
        s_stb_o = own & owner_stb & ~timeout_hit;
        s_we_o  = own & m_we_i[owner];
        s_adr_o = owner ? m_adr_i[63:32] : m_adr_i[31:0];
        s_sel_o = owner ? m_sel_i[7:4]   : m_sel_i[3:0];
        s_dat_o = owner ? m_dat_i[63:32] : m_dat_i[31:0];
        m_dat_o = s_dat_i;
        m_ack_o = {own & owner & s_ack_i, own & ~owner & s_ack_i};
        m_err_o = {owner & timeout_hit, ~owner & timeout_hit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            last_gnt <= 1'b1;
            wd       <= 8'd0;
        end else begin
            if (!own || s_ack_i || !owner_stb || timeout_hit)
                wd <= 8'd0;
            else
                wd <= wd + 8'd1;

            case (state)
                IDLE: begin
                    if (req == 2'b11) begin
                        if (round_robin != 0 && !last_gnt) begin
                            state <= OWN1;
                            gnt   <= 2'b10;
                        end else begin
                            state <= OWN0;
                            gnt   <= 2'b01;
                        end
                    end else if (req[0]) begin
                        state <= OWN0;
                        gnt   <= 2'b01;
                    end else if (req[1]) begin
                        state <= OWN1;
                        gnt   <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!m_cyc_i[0]) begin
                        state    <= IDLE;
                        gnt      <= 2'b00;
                        last_gnt <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m_cyc_i[1]) begin
                        state    <= IDLE;
                        gnt      <= 2'b00;
                        last_gnt <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - directed bench for wb_arbiter2 (round-robin and fixed-priority instances)
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cyc, stb, we;
    logic [63:0] adr, dat;
    logic [7:0]  sel;
    logic [31:0] s_dat;
    logic        s_ack;

    logic [31:0] a_m_dat, b_m_dat, a_s_adr, b_s_adr, a_s_dat, b_s_dat;
    logic [1:0]  a_ack, b_ack, a_err, b_err, a_gnt, b_gnt;
    logic        a_s_cyc, b_s_cyc, a_s_stb, b_s_stb, a_s_we, b_s_we;
    logic [3:0]  a_s_sel, b_s_sel;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.round_robin(1), .timeout(4)) dut_a (
        .clk(clk), .reset(reset), .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(adr), .m_sel_i(sel), .m_dat_i(dat), .m_dat_o(a_m_dat),
        .m_ack_o(a_ack), .m_err_o(a_err), .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb),
        .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_sel_o(a_s_sel), .s_dat_o(a_s_dat),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt(a_gnt)
    );

    wb_arbiter2 #(.round_robin(0), .timeout(4)) dut_b (
        .clk(clk), .reset(reset), .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(adr), .m_sel_i(sel), .m_dat_i(dat), .m_dat_o(b_m_dat),
        .m_ack_o(b_ack), .m_err_o(b_err), .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb),
        .s_we_o(b_s_we), .s_adr_o(b_s_adr), .s_sel_o(b_s_sel), .s_dat_o(b_s_dat),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt(b_gnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc = 2'b00; stb = 2'b00; we = 2'b00;
        adr = '0; dat = '0; sel = '0; s_dat = '0; s_ack = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_gnt", a_gnt, 2'b00);
        chk("rst_ack", a_ack, 2'b00);
        chk("rst_err", a_err, 2'b00);
        chk("rst_scyc", a_s_cyc, 1'b0);
        chk("rst_sstb", a_s_stb, 1'b0);

        // single read from master 0
        cyc = 2'b01; stb = 2'b01; adr[31:0] = 32'h100;
        #1;
        chk("rd_gnt_req_cycle", a_gnt, 2'b00);
        tick();
        chk("rd_gnt", a_gnt, 2'b01);
        chk("rd_sadr", a_s_adr, 32'h100);
        chk("rd_sstb", a_s_stb, 1'b1);
        tick();
        tick();
        s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        cyc = 2'b00; stb = 2'b00;
        #1;
        chk("rd_ack", a_ack, 2'b01);
        chk("rd_dat", a_m_dat, 32'hDEADBEEF);
        chk("rd_err", a_err, 2'b00);
        tick();
        s_ack = 1'b0;
        #1;
        chk("rd_idle", a_gnt, 2'b00);

        // contention, round robin
        do_reset();
        cyc = 2'b11; stb = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp;
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk("rr_gnt", a_gnt, exp);
            s_ack = 1'b1; cyc = ~exp; stb = ~exp;
            #1;
            chk("rr_ack", a_ack, exp);
            tick();
            s_ack = 1'b0;
            #1;
            chk("rr_gap", a_gnt, 2'b00);
            cyc = 2'b11; stb = 2'b11;
        end

        // contention, fixed priority
        do_reset();
        cyc = 2'b11; stb = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fp_gnt", b_gnt, 2'b01);
            s_ack = 1'b1; cyc = 2'b10; stb = 2'b10;
            #1;
            chk("fp_ack", b_ack, 2'b01);
            tick();
            s_ack = 1'b0;
            #1;
            chk("fp_gap", b_gnt, 2'b00);
            cyc = 2'b11; stb = 2'b11;
        end

        // bus lock by master 1
        do_reset();
        cyc = 2'b10; stb = 2'b10; we = 2'b10;
        sel[7:4] = 4'b0011; dat[63:32] = 32'h1234; adr[63:32] = 32'h200;
        tick();
        chk("lk_gnt", a_gnt, 2'b10);
        cyc = 2'b11; stb = 2'b11;
        for (int k = 0; k < 3; k++) begin
            s_ack = 1'b1;
            #1;
            chk("lk_sel", a_s_sel, 4'b0011);
            chk("lk_dat", a_s_dat, 32'h1234);
            chk("lk_we", a_s_we, 1'b1);
            chk("lk_ack", a_ack, 2'b10);
            tick();
            s_ack = 1'b0;
            #1;
            chk("lk_hold", a_gnt, 2'b10);
        end
        cyc = 2'b01; stb = 2'b01; we = 2'b00;
        tick();
        chk("lk_gap", a_gnt, 2'b00);
        tick();
        chk("lk_m0", a_gnt, 2'b01);

        // watchdog, timeout = 4
        do_reset();
        cyc = 2'b01; stb = 2'b01;
        tick();
        chk("wd_gnt", a_gnt, 2'b01);
        for (int k = 0; k < 4; k++) begin
            chk("wd_noerr", a_err, 2'b00);
            chk("wd_stb", a_s_stb, 1'b1);
            tick();
        end
        chk("wd_err", a_err, 2'b01);
        chk("wd_err_stb", a_s_stb, 1'b0);
        chk("wd_err_cyc", a_s_cyc, 1'b0);
        chk("wd_err_ack", a_ack, 2'b00);
        tick();
        chk("wd_pulse", a_err, 2'b00);
        chk("wd_restart", a_s_stb, 1'b1);
        chk("wd_owned", a_gnt, 2'b01);
        for (int k = 0; k < 4; k++) tick();
        s_ack = 1'b1;
        #1;
        chk("wd_ack_wins", a_ack, 2'b01);
        chk("wd_ack_noerr", a_err, 2'b00);
        chk("wd_ack_stb", a_s_stb, 1'b1);
        cyc = 2'b00; stb = 2'b00;
        tick();
        s_ack = 1'b0;

        // reset while master 0 owns, master 1 pending
        do_reset();
        cyc = 2'b01; stb = 2'b01;
        tick();
        chk("mr_gnt0", a_gnt, 2'b01);
        cyc = 2'b10; stb = 2'b10;
        reset = 1'b1;
        tick();
        reset = 1'b0; s_ack = 1'b1;
        #1;
        chk("mr_gnt", a_gnt, 2'b00);
        chk("mr_ack", a_ack, 2'b00);
        chk("mr_err", a_err, 2'b00);
        chk("mr_scyc", a_s_cyc, 1'b0);
        s_ack = 1'b0;
        tick();
        chk("mr_m1", a_gnt, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
